crank_signal_gen: RTL and testbench
===================================

# crank_signal_gen

Synthetic missing-tooth crank wheel generator: the transmit side of the crank capture path. It produces a tooth train, e.g. 60-2, with programmable pitch, duty and gap, paced by a clock-enable tick. The output drives the capture/filter/edge-detect chain in loopback and on the bench, and can also drive an external pin for ECU stimulation.

## Interface
- WIDTH_PER, 16: width of the per-slot tick counter and of the pitch/high configuration.
- WIDTH_TOOTH, 8: width of the slot index and of the tooth-count configuration.

- clk  in  1  system clock; all state is on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- ena  in  1  tick enable; counters advance only on clk cycles with ena=1.
- run  in  1  level request to generate.
- tooth_period  in  WIDTH_PER  ticks per slot; values below 2 are treated as 2.
- tooth_high  in  WIDTH_PER  ticks high per tooth; clamped to effective tooth_period-1.
- teeth_total  in  WIDTH_TOOTH  slots per revolution, including gap slots; 0 is treated as 1.
- teeth_gap  in  WIDTH_TOOTH  missing slots at the end of the revolution; values ≥ total make every slot a gap.
- q  out  1  generated tooth signal, registered.
- tooth_num  out  WIDTH_TOOTH  current slot index, 0..total-1.
- tooth_edge  out  1  one-clk pulse when a slot starts, gap slots included.
- rev_pulse  out  1  one-clk pulse when slot 0 starts.
- busy  out  1  1 while in RUN.

## Operation
- States:
  - IDLE: counters 0, q=0.
  - RUN: a phase counter p runs 0..P-1 inside slot s, and s runs 0..T-1.
- IDLE→RUN: on a cycle with ena=1 and run=1.
  - Sets p=0, s=0.
  - Latches all four config inputs.
  - Pulses tooth_edge and rev_pulse.
- In RUN, each ena=1 cycle:
  - If p<P-1: p+1.
  - Otherwise p=0 and slot end: s+1, or s=0 when s=T-1.
- Config latching:
  - Pitch P and high H are latched at every slot start.
  - Total T and gap G are latched only at slot-0 start, so the revolution geometry never changes mid-revolution.
- Gap slot: s ≥ T-G, computed with unsigned saturating subtraction.
- q = RUN & (p < H) & !gap(s). q is registered from next-state decode, so it always matches the current p/s registers.
- Stop: run is sampled only on the ena cycle that ends a slot.
  - run=0 there: → IDLE, with q=0, busy=0, tooth_num=0, and no edge pulses.
  - run=0 mid-slot: no effect; the slot completes.
- tooth_num = s. It holds between ena ticks.
- tooth_edge and rev_pulse last exactly one clk cycle, even when ena is continuously high.

## Timing
- Reset (rst=0, asynchronous):
  - State IDLE; p, s and the latched config all 0.
  - q=0, tooth_num=0, tooth_edge=0, rev_pulse=0, busy=0.
- After reset release: no activity until the first clk edge with ena=1 and run=1.
- Start latency: q, busy and the pulses are valid 1 clk after the start cycle.
  - q=1 if H>0 and slot 0 is not a gap.
- Per slot: q is high for H ticks, then low for P-H ticks (≥1).
  - Consecutive teeth always show a falling edge.
- Revolution length: T·P ticks.
- Reset asserted mid-slot forces the reset values immediately. No partial slot resumes after release.
- ena=0 freezes every register except the one-cycle pulses, which still clear.

## Test plan
- Basic 6-2 wheel.
  - Stimulus: P=4, H=2, T=6, G=2, ena=1, run=1.
  - Response: q repeats 1100×4 then 0000×2 (24 clk). rev_pulse every 24 clk. tooth_edge every 4 clk. tooth_num 0..5.
- Start and stop.
  - Stimulus: same config; drop run at p=1 of slot 3.
  - Response: slot 3 completes (q 1100), then IDLE. q=0 and busy=0 on the cycle after the slot end. No further pulses.
- Clamps.
  - Stimulus: P=1, H=9, T=0, G=0.
  - Response: behaves as P=2, H=1, T=1; q toggles 1010…; rev_pulse every 2 clk.
- Config change mid-run.
  - Stimulus: change P 4→8 at slot 2, p=1; change T 6→10 mid-revolution.
  - Response: slot 2 stays 4 ticks and slot 3 is 8. The new T takes effect only at the next slot 0.
- Tick pacing.
  - Stimulus: ena=1 every 3rd clk, P=4, H=2, T=6, G=2.
  - Response: the same sequence stretched ×3 (72 clk per revolution). Pulses stay 1 clk wide.
- Async reset.
  - Stimulus: assert rst=0 mid-tooth while q=1.
  - Response: q=0 and tooth_num=0 immediately, without a clk edge. Restart begins at slot 0.

Source files
------------

// File: rtl/crank_signal_gen.sv
`default_nettype none
// ============================================================================
// Module      : crank_signal_gen
// Description : Missing-tooth crank wheel generator (e.g. 60-2) with
//               programmable pitch, duty and gap, paced by a tick enable.
// Revision    : 1.0 - initial release
// ============================================================================
module crank_signal_gen #(
    parameter int WIDTH_PER   = 16,
    parameter int WIDTH_TOOTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic                   run,
    input  logic [WIDTH_PER-1:0]   tooth_period,
    input  logic [WIDTH_PER-1:0]   tooth_high,
    input  logic [WIDTH_TOOTH-1:0] teeth_total,
    input  logic [WIDTH_TOOTH-1:0] teeth_gap,
    output logic                   q,
    output logic [WIDTH_TOOTH-1:0] tooth_num,
    output logic                   tooth_edge,
    output logic                   rev_pulse,
    output logic                   busy
);

    localparam logic [WIDTH_PER-1:0]   C_PER_MIN   = WIDTH_PER'(2);
    localparam logic [WIDTH_PER-1:0]   C_PER_ONE   = WIDTH_PER'(1);
    localparam logic [WIDTH_TOOTH-1:0] C_TOOTH_ONE = WIDTH_TOOTH'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [WIDTH_PER-1:0]   r_p, w_p_nxt;
    logic [WIDTH_TOOTH-1:0] r_s, w_s_nxt;
    logic [WIDTH_PER-1:0]   r_per, w_per_nxt;
    logic [WIDTH_PER-1:0]   r_high, w_high_nxt;
    logic [WIDTH_TOOTH-1:0] r_total, w_total_nxt;
    logic [WIDTH_TOOTH-1:0] r_gap, w_gap_nxt;
    logic                   r_q, w_q_nxt;
    logic                   r_edge, w_edge_nxt;
    logic                   r_rev, w_rev_nxt;

    logic [WIDTH_PER-1:0]   w_per_eff;
    logic [WIDTH_PER-1:0]   w_high_eff;
    logic [WIDTH_TOOTH-1:0] w_total_eff;
    logic [WIDTH_TOOTH-1:0] w_gap_thr;
    logic                   w_slot_end;
    logic                   w_rev_end;

    // Clamped view of the live configuration, sampled at slot starts.
    always_comb begin
        w_per_eff   = (tooth_period < C_PER_MIN) ? C_PER_MIN : tooth_period;
        w_high_eff  = (tooth_high > (w_per_eff - C_PER_ONE)) ? (w_per_eff - C_PER_ONE)
                                                              : tooth_high;
        w_total_eff = (teeth_total == '0) ? C_TOOTH_ONE : teeth_total;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_p     <= '0;
            r_s     <= '0;
            r_per   <= '0;
            r_high  <= '0;
            r_total <= '0;
            r_gap   <= '0;
            r_q     <= 1'b0;
            r_edge  <= 1'b0;
            r_rev   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_p     <= w_p_nxt;
            r_s     <= w_s_nxt;
            r_per   <= w_per_nxt;
            r_high  <= w_high_nxt;
            r_total <= w_total_nxt;
            r_gap   <= w_gap_nxt;
            r_q     <= w_q_nxt;
            r_edge  <= w_edge_nxt;
            r_rev   <= w_rev_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_p_nxt     = r_p;
        w_s_nxt     = r_s;
        w_per_nxt   = r_per;
        w_high_nxt  = r_high;
        w_total_nxt = r_total;
        w_gap_nxt   = r_gap;
        w_edge_nxt  = 1'b0;
        w_rev_nxt   = 1'b0;
        w_slot_end  = (r_p >= (r_per - C_PER_ONE));
        w_rev_end   = (r_s >= (r_total - C_TOOTH_ONE));

        case (r_state)
            ST_IDLE: begin
                if (ena && run) begin
                    w_state_nxt = ST_RUN;
                    w_p_nxt     = '0;
                    w_s_nxt     = '0;
                    w_per_nxt   = w_per_eff;
                    w_high_nxt  = w_high_eff;
                    w_total_nxt = w_total_eff;
                    w_gap_nxt   = teeth_gap;
                    w_edge_nxt  = 1'b1;
                    w_rev_nxt   = 1'b1;
                end
            end
            ST_RUN: begin
                if (ena) begin
                    if (!w_slot_end) begin
                        w_p_nxt = r_p + C_PER_ONE;
                    end else if (!run) begin
                        w_state_nxt = ST_IDLE;
                        w_p_nxt     = '0;
                        w_s_nxt     = '0;
                    end else begin
                        w_p_nxt    = '0;
                        w_per_nxt  = w_per_eff;
                        w_high_nxt = w_high_eff;
                        w_edge_nxt = 1'b1;
                        if (w_rev_end) begin
                            // Revolution geometry only changes at slot 0.
                            w_s_nxt     = '0;
                            w_total_nxt = w_total_eff;
                            w_gap_nxt   = teeth_gap;
                            w_rev_nxt   = 1'b1;
                        end else begin
                            w_s_nxt = r_s + C_TOOTH_ONE;
                        end
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        w_gap_thr = (w_total_nxt > w_gap_nxt) ? (w_total_nxt - w_gap_nxt) : '0;
        w_q_nxt   = (w_state_nxt == ST_RUN) && (w_p_nxt < w_high_nxt) &&
                    (w_s_nxt < w_gap_thr);
    end

    assign q          = r_q;
    assign tooth_num  = r_s;
    assign tooth_edge = r_edge;
    assign rev_pulse  = r_rev;
    assign busy       = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_crank_signal_gen.sv
`default_nettype none
// Bench for crank_signal_gen: slot-waveform reference model feeding a
// scoreboard queue, checked every cycle by an independent monitor.
module tb_crank_signal_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        run;
    logic [15:0] tooth_period;
    logic [15:0] tooth_high;
    logic [7:0]  teeth_total;
    logic [7:0]  teeth_gap;
    logic        q;
    logic [7:0]  tooth_num;
    logic        tooth_edge;
    logic        rev_pulse;
    logic        busy;

    crank_signal_gen #(.WIDTH_PER(16), .WIDTH_TOOTH(8)) dut (
        .clk(clk), .rst(rst), .ena(ena), .run(run),
        .tooth_period(tooth_period), .tooth_high(tooth_high),
        .teeth_total(teeth_total), .teeth_gap(teeth_gap),
        .q(q), .tooth_num(tooth_num), .tooth_edge(tooth_edge),
        .rev_pulse(rev_pulse), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       q;
        logic [7:0] num;
        logic       te;
        logic       rev;
        logic       busy;
    } obs_t;

    obs_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   tick_cnt = 0;

    // Model: a running wheel holds the remaining tick levels of the current slot.
    bit   m_run = 0;
    bit   wave[$];
    int   m_slot = 0;
    int   m_T = 0;
    int   m_G = 0;

    function automatic void build_slot();
        int  pe, he, thr;
        bit  gap;
        pe  = (int'(tooth_period) < 2) ? 2 : int'(tooth_period);
        he  = (int'(tooth_high) > pe - 1) ? pe - 1 : int'(tooth_high);
        thr = (m_T > m_G) ? m_T - m_G : 0;
        gap = (m_slot >= thr);
        wave.delete();
        for (int i = 0; i < pe; i++) wave.push_back(!gap && (i < he));
    endfunction

    function automatic void latch_geometry();
        m_T = (teeth_total == 8'd0) ? 1 : int'(teeth_total);
        m_G = int'(teeth_gap);
    endfunction

    always @(posedge clk) begin : model
        obs_t e;
        bit   te, rv;
        te = 0;
        rv = 0;
        if (!rst) begin
            m_run  = 0;
            m_slot = 0;
            wave.delete();
        end else if (ena) begin
            if (!m_run) begin
                if (run) begin
                    m_run  = 1;
                    m_slot = 0;
                    latch_geometry();
                    build_slot();
                    te = 1;
                    rv = 1;
                end
            end else begin
                void'(wave.pop_front());
                if (wave.size() == 0) begin
                    if (!run) begin
                        m_run = 0;
                    end else begin
                        m_slot = m_slot + 1;
                        if (m_slot >= m_T) begin
                            m_slot = 0;
                            latch_geometry();
                            rv = 1;
                        end
                        build_slot();
                        te = 1;
                    end
                end
            end
        end
        e.q    = m_run ? wave[0] : 1'b0;
        e.num  = m_run ? 8'(m_slot) : 8'd0;
        e.te   = te;
        e.rev  = rv;
        e.busy = m_run;
        sb.push_back(e);
    end

    always @(negedge clk) begin : monitor
        obs_t got, exp;
        got = {q, tooth_num, tooth_edge, rev_pulse, busy};
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty at %0t: got q=%b num=%0d", $time, q, tooth_num);
        end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
                n_bad++;
                $display("FAIL cycle_outputs at %0t: got q=%b num=%0d edge=%b rev=%b busy=%b, want q=%b num=%0d edge=%b rev=%b busy=%b",
                         $time, got.q, got.num, got.te, got.rev, got.busy,
                         exp.q, exp.num, exp.te, exp.rev, exp.busy);
            end
        end
    end

    // mode 0: ena always high, 1: every third clk, 2: random.
    task automatic run_cycles(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            case (mode)
                0:       ena = 1'b1;
                1:       ena = (tick_cnt % 3 == 0);
                default: ena = 1'($urandom_range(0, 1));
            endcase
            tick_cnt++;
        end
    endtask

    task automatic set_cfg(input int p, input int h, input int t, input int g);
        tooth_period = 16'(p);
        tooth_high   = 16'(h);
        teeth_total  = 8'(t);
        teeth_gap    = 8'(g);
    endtask

    task automatic async_reset_check();
        bit seen;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            ena = 1'b1;
            if (q === 1'b1 && tooth_num != 8'd0) seen = 1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL async_wait_q_high: got q=%b, want q=1 within 200 clk", q);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (q !== 1'b0 || tooth_num !== 8'd0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset_immediate: got q=%b num=%0d busy=%b, want 0/0/0",
                     q, tooth_num, busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        ena = 1'b0;
        run = 1'b0;
        set_cfg(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Idle with ticks but no run request.
        run = 1'b0;
        run_cycles(5, 0);

        // Basic 6-2 wheel.
        set_cfg(4, 2, 6, 2);
        run = 1'b1;
        run_cycles(60, 0);

        // Stop at a random point; the slot in progress must complete.
        run_cycles($urandom_range(0, 23), 0);
        run = 1'b0;
        run_cycles(20, 0);

        // Clamps: P=1,H=9,T=0 behave as P=2,H=1,T=1.
        set_cfg(1, 9, 0, 0);
        run = 1'b1;
        run_cycles(20, 0);
        run = 1'b0;
        run_cycles(6, 0);

        // Config changes mid-slot and mid-revolution.
        set_cfg(4, 2, 6, 2);
        run = 1'b1;
        run_cycles(9, 0);
        tooth_period = 16'd8;
        run_cycles(5, 0);
        teeth_total = 8'd10;
        run_cycles(120, 0);
        run = 1'b0;
        run_cycles(20, 0);

        // Tick pacing at one ena per three clk.
        set_cfg(4, 2, 6, 2);
        run = 1'b1;
        run_cycles(160, 1);

        // Asynchronous reset mid-tooth, then restart from slot 0.
        async_reset_check();
        run_cycles(40, 0);

        // Randomized geometry, pacing and run requests.
        for (int seg = 0; seg < 30; seg++) begin
            set_cfg($urandom_range(0, 6), $urandom_range(0, 7),
                    $urandom_range(0, 8), $urandom_range(0, 9));
            run = ($urandom_range(0, 3) != 0);
            run_cycles($urandom_range(20, 80), $urandom_range(0, 2));
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
